cube_frame_capture: RTL

- Receive side of the 15-pin cube drive interface that cube_output transmits.
- Samples the pin bus, rebuilds the 512-bit cell frame and publishes each complete, in-order frame.
- Used for readback, self-check and as a bench scoreboard next to cube_output.
- Detects out-of-order row scans and resynchronises on the next row 0.

---
 rtl/cube_pkg.sv | 26 ++
 rtl/cube_frame_capture_if.sv | 25 ++
 rtl/cube_frame_capture_pin_sampler.sv | 30 +++
 rtl/cube_frame_capture.sv | 104 ++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared definitions for the cube drive interface: pin field layout,
// cell indexing and the capture state encoding.
package cube_pkg;

    localparam int CUBE_DIM   = 8;
    localparam int CELL_BITS  = 512;
    localparam int PIN_W      = 15;

    localparam int DATA_LSB   = 0;
    localparam int ROW_LSB    = 8;
    localparam int LAYER_LSB  = 11;
    localparam int STROBE_BIT = 14;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } cap_state_e;

    // Bit index of a cell inside the flattened 512-bit frame.
    function automatic logic [8:0] idx(input logic [2:0] layer,
                                       input logic [2:0] row,
                                       input logic [2:0] col);
        return {layer, row, col};
    endfunction

endpackage

// File: rtl/cube_frame_capture_if.sv
// Pin-side inputs and published-frame outputs of the cube frame capture block.
interface cube_frame_capture_if #(
    parameter int FRAME_CNT_W = 16
);
    import cube_pkg::*;

    logic [PIN_W-1:0]       Pins;
    logic                   Clr_err;
    logic [CELL_BITS-1:0]   Cells;
    logic                   Frame_valid;
    logic [FRAME_CNT_W-1:0] Frame_count;
    logic                   Seq_err;
    logic                   Capturing;

    modport master (
        output Pins, Clr_err,
        input  Cells, Frame_valid, Frame_count, Seq_err, Capturing
    );

    modport slave (
        input  Pins, Clr_err,
        output Cells, Frame_valid, Frame_count, Seq_err, Capturing
    );

endinterface

// File: rtl/cube_frame_capture_pin_sampler.sv
// Registers the cube pin bus once and emits a one-cycle row event on each
// rising edge of the load strobe, aligned with the registered fields.
module cube_frame_capture_pin_sampler
    import cube_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic [PIN_W-1:0] pins,
    output logic [PIN_W-2:0] fields_q,
    output logic             row_event
);

    logic [PIN_W-1:0] pins_r;
    logic             row_event_r;

    // Sample pins; pins_r[STROBE_BIT] doubles as the strobe history bit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pins_r      <= {PIN_W{1'b0}};
            row_event_r <= 1'b0;
        end else begin
            pins_r      <= pins;
            row_event_r <= pins[STROBE_BIT] & ~pins_r[STROBE_BIT];
        end
    end

    assign fields_q  = pins_r[PIN_W-2:0];
    assign row_event = row_event_r;

endmodule

// File: rtl/cube_frame_capture.sv
// Rebuilds 512-bit cube frames from the row-scanned pin bus and publishes
// each complete, in-order frame; out-of-order scans raise a sticky error.
module cube_frame_capture
    import cube_pkg::*;
#(
    parameter int FRAME_CNT_W = 16
) (
    input logic                 Clk,
    input logic                 Reset,
    cube_frame_capture_if.slave bus
);

    logic [PIN_W-2:0]       fields_s;
    logic                   row_event_s;
    logic [5:0]             addr_s;
    logic [CUBE_DIM-1:0]    data_s;
    logic [CELL_BITS-1:0]   shadow_next_s;

    logic [CELL_BITS-1:0]   shadow_r;
    logic [CELL_BITS-1:0]   cells_r;
    cap_state_e             state_r;
    logic [5:0]             exp_r;
    logic                   frame_valid_r;
    logic [FRAME_CNT_W-1:0] frame_count_r;
    logic                   seq_err_r;

    cube_frame_capture_pin_sampler u_sampler (
        .Clk       (Clk),
        .Reset     (Reset),
        .pins      (bus.Pins),
        .fields_q  (fields_s),
        .row_event (row_event_s)
    );

    assign addr_s = {fields_s[LAYER_LSB +: 3], fields_s[ROW_LSB +: 3]};
    assign data_s = fields_s[DATA_LSB +: CUBE_DIM];

    // Shadow buffer with the current row's byte merged in.
    always_comb begin
        shadow_next_s = shadow_r;
        shadow_next_s[idx(addr_s[5:3], addr_s[2:0], 3'd0) +: CUBE_DIM] = data_s;
    end

    // Capture FSM: row sequencing, frame publish, frame count and error flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shadow_r      <= {CELL_BITS{1'b0}};
            cells_r       <= {CELL_BITS{1'b0}};
            state_r       <= HUNT;
            exp_r         <= 6'd0;
            frame_valid_r <= 1'b0;
            frame_count_r <= {FRAME_CNT_W{1'b0}};
            seq_err_r     <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            // A set later in this block overrides the clear.
            if (bus.Clr_err) begin
                seq_err_r <= 1'b0;
            end
            if (row_event_s) begin
                case (state_r)
                    HUNT: begin
                        if (addr_s == 6'd0) begin
                            shadow_r <= shadow_next_s;
                            exp_r    <= 6'd1;
                            state_r  <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (addr_s == exp_r) begin
                            shadow_r <= shadow_next_s;
                            exp_r    <= exp_r + 6'd1;
                            if (addr_s == 6'd63) begin
                                cells_r       <= shadow_next_s;
                                frame_valid_r <= 1'b1;
                                frame_count_r <= frame_count_r + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            seq_err_r <= 1'b1;
                            if (addr_s == 6'd0) begin
                                shadow_r <= shadow_next_s;
                                exp_r    <= 6'd1;
                            end else begin
                                state_r <= HUNT;
                                exp_r   <= 6'd0;
                            end
                        end
                    end
                    default: begin
                        state_r <= HUNT;
                        exp_r   <= 6'd0;
                    end
                endcase
            end
        end
    end

    assign bus.Cells       = cells_r;
    assign bus.Frame_valid = frame_valid_r;
    assign bus.Frame_count = frame_count_r;
    assign bus.Seq_err     = seq_err_r;
    assign bus.Capturing   = (state_r == CAPTURE);

endmodule
